// File: rtl/load_scoreboard_pkg.sv
// Shared constants and helpers for the load-use scoreboard.
package load_scoreboard_pkg;

  localparam int STALL_W          = 6;
  localparam int REG_ADDR_W       = 5;
  localparam int NUM_GPR          = 32;
  localparam int ID_HOLD_BIT      = 2;
  localparam int EX_HOLD_BIT      = 3;
  localparam int LOAD_LAT_DEFAULT = 3;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Counter width able to hold the value lat; at least one bit.
  function automatic int cnt_width(input int lat);
    int w;
    w = $clog2(lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Number of set bits in a 32-bit mask.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] sum;
    sum = '0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + {5'b0, v[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/load_scoreboard_sb_entry.sv
// One scoreboard entry: countdown of EX advances until a load result is
// forwardable. Load wins over clear and decrement; rst and flush win over all.
module sb_entry
  import load_scoreboard_pkg::*;
#(
  parameter int LAT = LOAD_LAT_DEFAULT,
  parameter int CW  = cnt_width(LAT)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic load_i,
  input  logic clear_i,
  input  logic dec_i,
  output logic busy_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next-state: reset/flush clear, issue updates, then saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(LAT);
    end else if (clear_i) begin
      cnt_d = '0;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/load_scoreboard.sv
// Load-use scoreboard: tracks GPRs with loads still in flight and requests
// an ID stall when the instruction in ID reads one of them.
module load_scoreboard
  import load_scoreboard_pkg::*;
#(
  parameter int LOAD_LAT = LOAD_LAT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_raddr,
  input  logic [REG_ADDR_W-1:0] id_rt_raddr,
  input  logic                  id_we,
  input  logic [REG_ADDR_W-1:0] id_waddr,
  input  logic                  id_is_load,
  output logic                  stallreq_for_load,
  output logic [NUM_GPR-1:0]    busy_mask,
  output logic [5:0]            pending_cnt
);

  localparam int CW = cnt_width(LOAD_LAT);

  logic issue;
  logic issue_load;
  logic issue_alu;
  logic ex_adv;
  logic rs_hit;
  logic rt_hit;
  logic unused_stall;

  // Only the ID and EX hold bits matter here.
  assign unused_stall = ^{stall[5:4], stall[1:0]};

  // Instruction leaves ID this cycle; flush kills it.
  assign issue      = id_valid & (stall[ID_HOLD_BIT] == NoStop) & ~flush;
  assign issue_load = issue & id_we & id_is_load & (id_waddr != '0);
  assign issue_alu  = issue & id_we & ~id_is_load & (id_waddr != '0);
  assign ex_adv     = (stall[EX_HOLD_BIT] == NoStop);

  // $0 is hardwired zero and never tracked.
  assign busy_mask[0] = 1'b0;

  for (genvar g = 1; g < NUM_GPR; g++) begin : g_entry
    sb_entry #(
      .LAT (LOAD_LAT),
      .CW  (CW)
    ) u_entry (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush),
      .load_i  (issue_load & (id_waddr == REG_ADDR_W'(g))),
      .clear_i (issue_alu  & (id_waddr == REG_ADDR_W'(g))),
      .dec_i   (ex_adv),
      .busy_o  (busy_mask[g])
    );
  end

  // Zero-latency hazard check of ID source operands against registered state.
  always_comb begin
    rs_hit            = (id_rs_raddr != '0) & busy_mask[id_rs_raddr];
    rt_hit            = (id_rt_raddr != '0) & busy_mask[id_rt_raddr];
    stallreq_for_load = id_valid & (rs_hit | rt_hit);
    pending_cnt       = popcount32(busy_mask);
  end

endmodule

// File: tb/tb_load_scoreboard.sv
// Bench for load_scoreboard: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked every cycle by a timeline model.
module tb_load_scoreboard;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic        id_valid;
  logic [4:0]  id_rs_raddr;
  logic [4:0]  id_rt_raddr;
  logic        id_we;
  logic [4:0]  id_waddr;
  logic        id_is_load;
  logic        stallreq_for_load;
  logic [31:0] busy_mask;
  logic [5:0]  pending_cnt;

  int checks = 0;
  int passes = 0;

  load_scoreboard #(.LOAD_LAT(LAT)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .stall             (stall),
    .id_valid          (id_valid),
    .id_rs_raddr       (id_rs_raddr),
    .id_rt_raddr       (id_rt_raddr),
    .id_we             (id_we),
    .id_waddr          (id_waddr),
    .id_is_load        (id_is_load),
    .stallreq_for_load (stallreq_for_load),
    .busy_mask         (busy_mask),
    .pending_cnt       (pending_cnt)
  );

  // Clock and reset-free clock generation.
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a global count of EX advances plus, per register, the
  // advance count at which its load was issued. A register is busy while a
  // load is recorded and fewer than LAT advances have passed since issue.
  // ---------------------------------------------------------------------------
  int adv_total = 0;
  int issue_adv [32];
  bit pend      [32];
  bit model_ok  = 1'b0;

  function automatic bit m_busy(input int r);
    return (r != 0) && pend[r] && ((adv_total - issue_adv[r]) < LAT);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
      adv_total = 0;
      model_ok  = 1'b1;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    end else begin
      if (!stall[3]) adv_total = adv_total + 1;
      if (id_valid && !stall[2] && id_we && id_waddr != 5'd0) begin
        if (id_is_load) begin
          pend[id_waddr]      = 1'b1;
          issue_adv[id_waddr] = adv_total;
        end else begin
          pend[id_waddr] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle compare against the model once it has seen a reset edge.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [31:0] exp_mask;
      int          exp_cnt;
      logic        exp_req;
      exp_mask = '0;
      exp_cnt  = 0;
      for (int r = 0; r < 32; r++) begin
        if (m_busy(r)) begin
          exp_mask[r] = 1'b1;
          exp_cnt++;
        end
      end
      exp_req = id_valid && (m_busy(int'(id_rs_raddr)) || m_busy(int'(id_rt_raddr)));
      chk("model_busy_mask", busy_mask, exp_mask);
      chk("model_pending_cnt", {26'b0, pending_cnt}, exp_cnt);
      chk("model_stallreq", {31'b0, stallreq_for_load}, {31'b0, exp_req});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_idle();
    rst = 1'b0; flush = 1'b0; stall = 6'd0;
    id_valid = 1'b0; id_rs_raddr = 5'd0; id_rt_raddr = 5'd0;
    id_we = 1'b0; id_waddr = 5'd0; id_is_load = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd);
    set_idle();
    id_valid = 1'b1; id_we = 1'b1; id_is_load = 1'b1; id_waddr = rd;
  endtask

  task automatic set_alu(input logic [4:0] rd);
    set_idle();
    id_valid = 1'b1; id_we = 1'b1; id_is_load = 1'b0; id_waddr = rd;
  endtask

  task automatic set_reader(input logic [4:0] rs, input logic [4:0] rt);
    set_idle();
    id_valid = 1'b1; id_rs_raddr = rs; id_rt_raddr = rt;
  endtask

  // Let one rising edge consume the current inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios and random traffic
  // ---------------------------------------------------------------------------
  initial begin
    set_idle();
    do_reset();

    // Reset state.
    set_reader(5'd5, 5'd3);
    @(negedge clk);
    chk("reset_busy_mask", busy_mask, 32'h0);
    chk("reset_pending_cnt", {26'b0, pending_cnt}, 32'd0);
    chk("reset_stallreq", {31'b0, stallreq_for_load}, 32'd0);

    // lw $5 then reader of $5: stall for three cycles, clear on the fourth.
    set_load(5'd5);
    step();
    set_reader(5'd5, 5'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lw5_stallreq", {31'b0, stallreq_for_load}, (k < 3) ? 32'd1 : 32'd0);
      chk("lw5_busy_mask", busy_mask, (k < 3) ? 32'h20 : 32'h0);
      step();
    end

    // lw $5 with EX held two cycles: request lasts five cycles.
    set_load(5'd5);
    step();
    for (int k = 0; k < 6; k++) begin
      set_reader(5'd0, 5'd5);
      stall = (k < 2) ? 6'b001000 : 6'b000000;
      @(negedge clk);
      chk("exhold_stallreq", {31'b0, stallreq_for_load}, (k < 5) ? 32'd1 : 32'd0);
      step();
    end

    // lw $5 superseded by addu $5 on the next cycle.
    set_load(5'd5);
    step();
    set_alu(5'd5);
    @(negedge clk);
    chk("supersede_busy_before", busy_mask, 32'h20);
    chk("supersede_cnt_before", {26'b0, pending_cnt}, 32'd1);
    step();
    set_idle();
    @(negedge clk);
    chk("supersede_busy_after", busy_mask, 32'h0);
    chk("supersede_cnt_after", {26'b0, pending_cnt}, 32'd0);

    // lw $3, lw $4 back to back, flush on the third cycle.
    set_load(5'd3);
    step();
    set_load(5'd4);
    step();
    set_idle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", busy_mask, 32'h18);
    chk("flush_cnt_before", {26'b0, pending_cnt}, 32'd2);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", busy_mask, 32'h0);
    chk("flush_cnt_after", {26'b0, pending_cnt}, 32'd0);

    // lw $0 is never tracked.
    set_load(5'd0);
    step();
    set_reader(5'd0, 5'd0);
    @(negedge clk);
    chk("r0_stallreq", {31'b0, stallreq_for_load}, 32'd0);
    chk("r0_busy_mask", busy_mask, 32'h0);

    // Reset with two loads pending.
    set_load(5'd3);
    step();
    set_load(5'd4);
    step();
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cnt_before", {26'b0, pending_cnt}, 32'd2);
    step();
    set_reader(5'd3, 5'd0);
    @(negedge clk);
    chk("rst_busy_after", busy_mask, 32'h0);
    chk("rst_stallreq_after", {31'b0, stallreq_for_load}, 32'd0);
    step();

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      stall       = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 2) != 0) stall[2] = 1'b0;
      if ($urandom_range(0, 2) != 0) stall[3] = 1'b0;
      id_valid    = ($urandom_range(0, 5) != 0);
      id_rs_raddr = 5'($urandom_range(0, 7));
      id_rt_raddr = 5'($urandom_range(0, 7));
      id_we       = ($urandom_range(0, 3) != 0);
      id_waddr    = 5'($urandom_range(0, 7));
      id_is_load  = ($urandom_range(0, 1) != 0);
      step();
    end

    set_idle();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
